// File: rtl/sd_spi_engine.sv
// Byte-level SPI mode-0 master for the SD card controller.
// Each accepted command shifts one byte, sets chip select, or sends N idle bytes of clocks.
module sd_spi_engine #(
  parameter int unsigned DIV_SLOW = 32,
  parameter int unsigned DIV_FAST = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] tx,
  input  logic       fast,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs
);

  localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int unsigned CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [CNT_W-1:0] LOAD_SLOW = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] LOAD_FAST = CNT_W'(DIV_FAST - 1);

  localparam logic [1:0] CMD_XFER    = 2'b00;
  localparam logic [1:0] CMD_CS_LOW  = 2'b01;
  localparam logic [1:0] CMD_CS_HIGH = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CSOP, ST_FIN} state_t;

  state_t           r_state;
  logic [1:0]       r_cmd;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_hp;
  logic [7:0]       r_bytes;
  logic [7:0]       r_txsh;
  logic [7:0]       r_rxsh;
  logic [7:0]       r_rx;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_cs;
  logic             r_cs_cmd;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_load;
  logic             w_expire;

  assign w_load   = fast ? LOAD_FAST : LOAD_SLOW;
  assign w_expire = (r_cnt == '0);

  assign busy     = r_busy;
  assign done     = r_done;
  assign rx       = r_rx;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;
  assign spi_cs   = r_cs;

  // r_hp counts completed half-periods within the current byte; even count -> next boundary is a rise
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cmd    <= CMD_XFER;
      r_div    <= '0;
      r_cnt    <= '0;
      r_hp     <= '0;
      r_bytes  <= '0;
      r_txsh   <= '1;
      r_rxsh   <= '0;
      r_rx     <= '0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b1;
      r_cs     <= 1'b1;
      r_cs_cmd <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FIN: begin
          r_state <= ST_IDLE;
          if (start) begin
            r_busy  <= 1'b1;
            r_cmd   <= cmd;
            r_div   <= w_load;
            r_cnt   <= w_load;
            r_hp    <= '0;
            r_bytes <= tx;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b1;
            r_txsh  <= '1;
            case (cmd)
              CMD_XFER: begin
                r_mosi  <= tx[7];
                r_txsh  <= {tx[6:0], 1'b1};
                r_state <= ST_SHIFT;
              end
              CMD_CS_LOW: begin
                r_cs     <= 1'b0;
                r_cs_cmd <= 1'b0;
                r_state  <= ST_CSOP;
              end
              CMD_CS_HIGH: begin
                r_cs     <= 1'b1;
                r_cs_cmd <= 1'b1;
                r_state  <= ST_CSOP;
              end
              default: begin
                // idle clocks: CS forced high only while the command runs
                r_cs    <= 1'b1;
                r_state <= (tx == 8'd0) ? ST_CSOP : ST_SHIFT;
              end
            endcase
          end
        end
        ST_CSOP: begin
          r_cs    <= r_cs_cmd;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_FIN;
        end
        ST_SHIFT: begin
          if (w_expire) begin
            r_cnt <= r_div;
            r_hp  <= r_hp + 4'd1;
            if (!r_hp[0]) begin
              r_sclk <= 1'b1;
              r_rxsh <= {r_rxsh[6:0], spi_miso};
            end else begin
              r_sclk <= 1'b0;
              if (r_hp != 4'd15) begin
                r_mosi <= r_txsh[7];
                r_txsh <= {r_txsh[6:0], 1'b1};
              end else if (r_cmd == CMD_XFER) begin
                r_rx    <= r_rxsh;
                r_mosi  <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_FIN;
              end else if (r_bytes == 8'd1) begin
                r_cs    <= r_cs_cmd;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_FIN;
              end else begin
                r_bytes <= r_bytes - 8'd1;
              end
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_engine.sv
// Self-checking bench for sd_spi_engine: vector table plus multi-cycle corner sequences,
// with a done-time scoreboard and a mode-0 slave model.
module tb_sd_spi_engine;

  localparam logic [1:0] C_XFER = 2'b00;
  localparam logic [1:0] C_CSL  = 2'b01;
  localparam logic [1:0] C_CSH  = 2'b10;
  localparam logic [1:0] C_IDLE = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       fast  = 1'b0;
  logic [1:0] cmd   = 2'b00;
  logic [7:0] tx    = 8'h00;
  logic       spi_miso = 1'b1;
  logic       busy, done, spi_sclk, spi_mosi, spi_cs;
  logic [7:0] rx;

  sd_spi_engine #(.DIV_SLOW(32), .DIV_FAST(1)) dut (
    .clock(clock), .reset(reset), .start(start), .cmd(cmd), .tx(tx), .fast(fast),
    .busy(busy), .done(done), .rx(rx), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs(spi_cs)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // scoreboard: expected rx and done edge, pushed at issue, popped on done
  typedef struct {
    logic [7:0] rx;
    int         cyc;
  } sb_t;
  sb_t sb[$];

  // driver-owned controls read by the monitor
  int         mon_gen    = 0;
  logic       mon_idle   = 1'b0;
  logic [7:0] slave_byte = 8'h00;

  // monitor-owned statistics
  int         rises, first_rise, last_rise, min_sp, max_sp, done_cnt;
  logic [7:0] mosi_cap;
  logic       idle_bad;
  logic       prev_sclk;

  initial begin
    int  seen_gen = 0;
    int  sp;
    sb_t e;
    rises = 0; first_rise = -1; last_rise = 0; min_sp = 1 << 30; max_sp = 0;
    done_cnt = 0; mosi_cap = 8'h00; idle_bad = 1'b0; prev_sclk = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_gen != seen_gen) begin
        seen_gen = mon_gen; rises = 0; first_rise = -1; min_sp = 1 << 30; max_sp = 0;
        mosi_cap = 8'h00; idle_bad = 1'b0;
      end
      if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (rises == 0) first_rise = cyc;
        else begin
          sp = cyc - last_rise;
          if (sp < min_sp) min_sp = sp;
          if (sp > max_sp) max_sp = sp;
        end
        last_rise = cyc;
        if (rises < 8) mosi_cap = {mosi_cap[6:0], spi_mosi};
        rises++;
      end
      if (mon_idle && busy === 1'b1 && (spi_cs !== 1'b1 || spi_mosi !== 1'b1)) idle_bad = 1'b1;
      prev_sclk = spi_sclk;
      // slave presents the next bit, MSB first, ahead of each rise
      spi_miso = slave_byte[3'd7 - 3'(rises)];
      if (done === 1'b1) begin
        done_cnt++;
        chk("done_busy_exclusive", 32'(busy), 0);
        chk("done_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rx_at_done", 32'(rx), 32'(e.rx));
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic start_cmd(input logic [1:0] c, input logic [7:0] t, input logic f,
                           input logic [7:0] sl, input logic [7:0] erx, input int lat,
                           output int t0);
    @(negedge clock); #1;
    mon_gen++;
    slave_byte = sl; mon_idle = (c == C_IDLE);
    cmd = c; tx = t; fast = f; start = 1'b1;
    t0 = cyc + 1;
    sb.push_back('{rx: erx, cyc: t0 + lat});
    @(negedge clock); #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 1);
  endtask

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while (done_cnt <= base && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    chk("done_within_budget", 32'(done_cnt > base), 1);
  endtask

  task automatic settle();
    repeat (2) begin @(negedge clock); #1; end
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] tx;
    logic       fast;
    logic [7:0] slave;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
    int         exp_rises;
    int         lat;
    logic       exp_cs;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin
    int t0, base, d1;

    vecs[0] = '{C_CSL,  8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 0,  1,    1'b0};
    vecs[1] = '{C_XFER, 8'hA5, 1'b1, 8'h3C, 8'h3C, 8'hA5, 8,  16,   1'b0};
    vecs[2] = '{C_IDLE, 8'd10, 1'b0, 8'h00, 8'h3C, 8'hFF, 80, 5120, 1'b0};
    vecs[3] = '{C_XFER, 8'h00, 1'b1, 8'hFF, 8'hFF, 8'h00, 8,  16,   1'b0};
    vecs[4] = '{C_IDLE, 8'd0,  1'b1, 8'h00, 8'hFF, 8'h00, 0,  1,    1'b0};
    vecs[5] = '{C_CSH,  8'h00, 1'b1, 8'h00, 8'hFF, 8'h00, 0,  1,    1'b1};
    vecs[6] = '{C_XFER, 8'h3C, 1'b0, 8'hA5, 8'hA5, 8'h3C, 8,  512,  1'b1};
    vecs[7] = '{C_CSL,  8'h00, 1'b1, 8'h00, 8'hA5, 8'h00, 0,  1,    1'b0};

    // reset, then quiet cycles
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    repeat (10) begin @(negedge clock); #1; end
    chk("reset_sclk", 32'(spi_sclk), 0);
    chk("reset_mosi", 32'(spi_mosi), 1);
    chk("reset_cs",   32'(spi_cs),   1);
    chk("reset_busy", 32'(busy),     0);
    chk("reset_done", 32'(done),     0);
    chk("reset_rx",   32'(rx),       0);

    for (int i = 0; i < NV; i++) begin
      int   d;
      vec_t v;
      v = vecs[i];
      d = v.fast ? 1 : 32;
      base = done_cnt;
      start_cmd(v.cmd, v.tx, v.fast, v.slave, v.exp_rx, v.lat, t0);
      wait_done(base, v.lat + 20);
      settle();
      chk("sclk_rises", rises, v.exp_rises);
      if (v.exp_rises > 0) begin
        chk("mosi_bits", 32'(mosi_cap), 32'(v.exp_mosi));
        chk("first_rise", first_rise, t0 + d);
      end
      if (v.exp_rises > 1) begin
        chk("min_period", min_sp, 2 * d);
        chk("max_period", max_sp, 2 * d);
      end
      if (v.cmd == C_IDLE) chk("idle_mosi_cs_high", 32'(idle_bad), 0);
      chk("cs_after", 32'(spi_cs), 32'(v.exp_cs));
      chk("idle_after", 32'(busy), 0);
      chk("mosi_idle_after", 32'(spi_mosi), 1);
    end

    // slow transfer: fast toggle and a second start mid-transfer are ignored
    base = done_cnt;
    start_cmd(C_XFER, 8'hFF, 1'b0, 8'h81, 8'h81, 512, t0);
    repeat (100) begin @(negedge clock); #1; end
    fast = 1'b1; cmd = C_CSH; tx = 8'h00; start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0; fast = 1'b0;
    wait_done(base, 600);
    repeat (5) begin @(negedge clock); #1; end
    chk("ignored_start_one_done", done_cnt - base, 1);
    chk("ignored_rises", rises, 8);
    chk("ignored_first_rise", first_rise, t0 + 32);
    chk("ignored_min_period", min_sp, 64);
    chk("ignored_max_period", max_sp, 64);
    chk("ignored_mosi", 32'(mosi_cap), 32'hFF);
    chk("ignored_cs", 32'(spi_cs), 0);

    // back-to-back transfers with start held through done
    base = done_cnt;
    @(negedge clock); #1;
    mon_gen++; slave_byte = 8'hC3; mon_idle = 1'b0;
    cmd = C_XFER; tx = 8'h5A; fast = 1'b1; start = 1'b1;
    t0 = cyc + 1;
    sb.push_back('{rx: 8'hC3, cyc: t0 + 16});
    @(negedge clock); #1;
    tx = 8'h96;
    wait_done(base, 40);
    d1 = cyc;
    mon_gen++; slave_byte = 8'h69;
    sb.push_back('{rx: 8'h69, cyc: d1 + 17});
    @(negedge clock); #1;
    start = 1'b0;
    wait_done(base + 1, 40);
    settle();
    chk("b2b_done_count", done_cnt - base, 2);
    chk("b2b_first_rise", first_rise, d1 + 2);
    chk("b2b_mosi", 32'(mosi_cap), 32'h96);
    chk("b2b_rx", 32'(rx), 32'h69);

    // reset during the seventh half-period of a transfer
    start_cmd(C_XFER, 8'h5A, 1'b1, 8'hF0, 8'h00, 16, t0);
    repeat (6) begin @(negedge clock); #1; end
    reset = 1'b1;
    sb.delete();
    base = done_cnt;
    @(negedge clock); #1;
    chk("abort_sclk", 32'(spi_sclk), 0);
    chk("abort_cs",   32'(spi_cs),   1);
    chk("abort_busy", 32'(busy),     0);
    chk("abort_rx",   32'(rx),       0);
    reset = 1'b0;
    repeat (30) begin @(negedge clock); #1; end
    chk("abort_no_done", done_cnt - base, 0);
    chk("abort_stays_idle", 32'(busy), 0);
    chk("abort_mosi", 32'(spi_mosi), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
